// File: rtl/mux32_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the 32:1 mux.
package mux_arb_pkg;

    localparam int N      = 32;
    localparam int SELW   = 5;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/mux32_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping at N-1.
module rr_pick #(
    parameter int N    = mux_arb_pkg::N,
    parameter int SELW = mux_arb_pkg::SELW
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] winner,
    output logic            any_req
);

    logic [SELW-1:0] idx;

    // Scan from the farthest slot back to ptr so the nearest hit is written last.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = |req;
        for (int i = N - 1; i >= 0; i--) begin
            idx = SELW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the shared 32:1 mux select and one-hot grant.
// Optional build macro ARB_LOCK_EN: lock suppresses the hold-limit timeout while held.
module mux32_rr_arbiter #(
    parameter int N        = mux_arb_pkg::N,
    parameter int SELW     = mux_arb_pkg::SELW,
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            req,
    input  logic                    rel,
    input  logic                    lock,
    output logic [SELW-1:0]         sel,
    output logic [N-1:0]            gnt,
    output logic                    gnt_valid,
    output logic [7:0]              hold_cnt,
    output logic                    preempt,
    output mux_arb_pkg::state_e     state_dbg
);

    import mux_arb_pkg::*;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    state_e            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              preempt_q, preempt_d;

    logic [SELW-1:0]   winner;
    logic              any_req;
    logic              timeout_en;
    logic              to_hit;
    logic              owner_drop;
    logic              busy_exit;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

`ifdef ARB_LOCK_EN
    assign timeout_en = ~lock;
`else
    logic lock_unused;
    assign lock_unused = lock;
    assign timeout_en  = 1'b1;
`endif

    assign to_hit     = timeout_en && (hold_cnt_q == HOLD_LAST);
    assign owner_drop = ~req[sel_q];
    assign busy_exit  = rel || owner_drop || to_hit;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d         = BUSY;
                    sel_d           = winner;
                    gnt_d           = '0;
                    gnt_d[winner]   = 1'b1;
                    gnt_valid_d     = 1'b1;
                    hold_cnt_d      = '0;
                end
            end
            BUSY: begin
                if (busy_exit) begin
                    state_d     = GAP;
                    ptr_d       = (sel_q == SELW'(N - 1)) ? '0 : sel_q + 1'b1;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    // Preempt flags only a pure timeout; release or drop wins a tie.
                    preempt_d   = to_hit && !rel && !owner_drop;
                end else begin
                    hold_cnt_d  = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            hold_cnt_q  <= hold_cnt_d;
            preempt_q   <= preempt_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign hold_cnt  = hold_cnt_q;
    assign preempt   = preempt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Bench for mux32_rr_arbiter: directed stimulus pushes expected grants, a negedge monitor checks them.
module tb_mux32_rr_arbiter;

    import mux_arb_pkg::*;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic          rel = 1'b0;
    logic          lock = 1'b0;
    logic [4:0]    sel;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [7:0]    hold_cnt;
    logic          preempt;
    state_e        state_dbg;

    mux32_rr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rel       (rel),
        .lock      (lock),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt),
        .preempt   (preempt),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] sel;
        int         len;
        logic       pre;
        logic       abort;
    } grant_t;

    grant_t exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_grant(input logic [4:0] s, input int len, input logic pre, input logic abort);
        grant_t g;
        g.sel = s;
        g.len = len;
        g.pre = pre;
        g.abort = abort;
        exp_q.push_back(g);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (!gnt_valid && n < 40) begin
            tick();
            n++;
        end
        if (!gnt_valid) check("wait_grant_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (gnt_valid && n < 400) begin
            tick();
            n++;
        end
        if (gnt_valid) check("wait_end_timeout", 64'd1, 64'd0);
    endtask

    task automatic release_after(input int hold);
        wait_grant();
        repeat (hold) tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
    endtask

    // ---------------- monitor ----------------
    grant_t cur;
    logic   in_grant = 1'b0;
    logic   have_prev = 1'b0;
    int     cyc = 0;
    int     idle_run = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (in_grant) check("reset_abort_expected", 64'(cur.abort), 64'd1);
            in_grant = 1'b0;
            have_prev = 1'b0;
            idle_run = 0;
        end else if (gnt_valid) begin
            if (!in_grant) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 64'(sel), 64'h3f);
                    cur.sel = sel;
                    cur.len = -1;
                    cur.pre = 1'b0;
                    cur.abort = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                end
                check("grant_sel", 64'(sel), 64'(cur.sel));
                if (have_prev) check("gap_spacing_ok", 64'(idle_run >= 2), 64'd1);
                in_grant = 1'b1;
                cyc = 0;
            end
            check("grant_onehot", 64'(gnt), 64'(32'd1 << cur.sel));
            check("hold_cnt_busy", 64'(hold_cnt), 64'((cyc > 255) ? 255 : cyc));
            check("preempt_during_grant", 64'(preempt), 64'd0);
            cyc++;
        end else begin
            if (in_grant) begin
                check("grant_aborted_flag", 64'(cur.abort), 64'd0);
                check("grant_len", 64'(cyc), 64'(cur.len));
                check("preempt_at_exit", 64'(preempt), 64'(cur.pre));
                in_grant = 1'b0;
                have_prev = 1'b1;
                idle_run = 0;
            end else begin
                check("preempt_idle", 64'(preempt), 64'd0);
            end
            check("gnt_idle", 64'(gnt), 64'd0);
            check("hold_cnt_idle", 64'(hold_cnt), 64'd0);
            check("sel_hold_idle", 64'(sel), 64'(have_prev ? cur.sel : 5'd0));
            idle_run++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        #2;
        check("rst_gnt_valid", 64'(gnt_valid), 64'd0);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_sel", 64'(sel), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_no_req", 64'(gnt_valid), 64'd0);
        check("idle_state", 64'(state_dbg), 64'(IDLE));

        // Single requester 3: release, regrant after gap, then drop.
        rel = 1'b1;
        tick();
        rel = 1'b0;
        expect_grant(5'd3, 1, 1'b0, 1'b0);
        expect_grant(5'd3, 2, 1'b0, 1'b0);
        req = 32'h0000_0008;
        tick();
        check("latency_valid", 64'(gnt_valid), 64'd1);
        check("latency_sel", 64'(sel), 64'd3);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        wait_grant();
        tick();
        req = '0;
        tick();
        repeat (3) tick();

        // Reset mid-grant drops everything at once.
        expect_grant(5'd3, 0, 1'b0, 1'b1);
        req = 32'h0000_0008;
        wait_grant();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(gnt_valid), 64'd0);
        check("async_rst_gnt", 64'(gnt), 64'd0);
        check("async_rst_sel", 64'(sel), 64'd0);
        check("async_rst_hold", 64'(hold_cnt), 64'd0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 64'(state_dbg), 64'(IDLE));
        check("post_rst_valid", 64'(gnt_valid), 64'd0);

        // Wrap: pointer back at 0 after reset, so 0,31,0,31.
        expect_grant(5'd0, 2, 1'b0, 1'b0);
        expect_grant(5'd31, 2, 1'b0, 1'b0);
        expect_grant(5'd0, 2, 1'b0, 1'b0);
        expect_grant(5'd31, 2, 1'b0, 1'b0);
        req = 32'h8000_0001;
        for (int k = 0; k < 4; k++) release_after(1);
        req = '0;
        repeat (3) tick();

        // Timeout on 4, coincident rel+timeout on 5, drop on 4, drop on 5.
        expect_grant(5'd4, 16, 1'b1, 1'b0);
        expect_grant(5'd5, 16, 1'b0, 1'b0);
        expect_grant(5'd4, 4, 1'b0, 1'b0);
        expect_grant(5'd5, 1, 1'b0, 1'b0);
        req = 32'h0000_0030;
        wait_grant();
        wait_end();
        release_after(15);
        wait_grant();
        repeat (3) tick();
        req = 32'h0000_0020;
        tick();
        wait_grant();
        req = '0;
        tick();
        repeat (3) tick();

        // Lock behaviour on requester 1 (pointer sits at 6).
        lock = 1'b1;
`ifdef ARB_LOCK_EN
        expect_grant(5'd1, 301, 1'b0, 1'b0);
        req = 32'h0000_0002;
        wait_grant();
        repeat (300) tick();
        check("lock_hold_sat", 64'(hold_cnt), 64'd255);
        check("lock_preempt", 64'(preempt), 64'd0);
        req = '0;
        tick();
`else
        expect_grant(5'd1, 16, 1'b1, 1'b0);
        req = 32'h0000_0002;
        wait_grant();
        wait_end();
        req = '0;
`endif
        lock = 1'b0;

        n = 0;
        while ((exp_q.size() != 0 || in_grant) && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux32_rr_arbiter.md
Name: mux32_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32:1 single-bit mux.
- Accepts up to 32 request lines, picks one winner, and drives the mux select plus a one-hot grant.
- Holds the grant until the winner releases it or a hold limit expires, then rotates priority.
- Sits directly in front of the structural 32:1 mux; its sel output connects straight to the mux sel input.

Parameters:
- N, 32, number of requesters (equals mux data width).
- SELW, 5, select width, clog2(N).
- MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation, range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request per requester, level-sensitive.
- rel  input  1  release pulse from the current owner.
- lock  input  1  owner requests no forced rotation (used only when the optional feature is compiled in).
- sel  output  SELW  select to the 32:1 mux, registered.
- gnt  output  N  one-hot grant, registered, all-zero when idle.
- gnt_valid  output  1  sel/gnt are valid and the mux output may be sampled.
- hold_cnt  output  8  cycles elapsed in the current grant (debug/observe).
- preempt  output  1  one-cycle pulse when a grant ends by hold timeout.

Behaviour:
- Reset (async on rst_n low): state=IDLE, sel=0, gnt=0, gnt_valid=0, hold_cnt=0, preempt=0, priority pointer ptr=0. Reset mid-grant drops the grant immediately; no pulse is generated.
- FSM states: IDLE, BUSY, GAP.
- IDLE:
  - If req==0: stay in IDLE.
  - Else: winner = first set bit scanning ptr, ptr+1, ..., wrapping from N-1 to 0.
  - Next edge: sel=winner, gnt=1<<winner, gnt_valid=1, hold_cnt=0, state=BUSY.
  - Latency is 1 clock from req sampled high to gnt_valid high.
- BUSY:
  - hold_cnt increments each cycle, saturating at 255.
  - Exit at the next edge when any one of these is true:
    - (a) rel=1
    - (b) req[sel]=0 (owner dropped its request)
    - (c) hold_cnt==MAX_HOLD-1 (timeout)
  - On exit: ptr=sel+1 mod N (31 wraps to 0), gnt=0, gnt_valid=0, hold_cnt=0, state=GAP.
  - preempt=1 for one cycle only when (c) is the sole cause. If rel and timeout coincide, the exit counts as a release, so preempt=0.
- GAP: exactly one idle cycle (all outputs idle), then IDLE. This gives a guaranteed mux settle/turnaround bubble, so the minimum inter-grant spacing is 2 cycles.
- rel while in IDLE or GAP is ignored. Requests that change during BUSY do not affect the current grant.
- Fairness: after granting i, requester i has lowest priority. Every requester with a continuously asserted req is granted within N grants.
- sel holds its last value while idle. Only gnt_valid qualifies it.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined: while in BUSY with lock=1, timeout exit (c) is suppressed. hold_cnt still counts and saturates at 255, and preempt never fires during a locked grant. Exits (a) and (b) still apply.
- Undefined: the lock port exists but is ignored; timeout always applies.

Decomposition:
- Shared package mux_arb_pkg:
  - state enum (IDLE, BUSY, GAP)
  - N, SELW, HOLD_W=8 constants
- One sub-module, rr_pick:
  - Combinational rotate/priority-encode.
  - Inputs: req, ptr.
  - Outputs: winner index, any_req.
  - Instantiated once inside mux32_rr_arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-grant -> gnt=0, gnt_valid=0, sel=0, ptr=0 asynchronously. Deassert with req=0 -> stays IDLE.
- Single requester: req=32'h0000_0008 -> one clock later sel=3, gnt=32'h8, gnt_valid=1. Pulse rel -> next edge gnt_valid=0, then 1-cycle GAP, then regrant sel=3.
- Round-robin wrap: req=32'h8000_0001 held, each owner releases after 2 cycles -> grant order sel=0,31,0,31. Confirm ptr wrap 31->0.
- Timeout: req=32'h0000_0030 held, no rel, MAX_HOLD=16 -> sel=4 for 16 cycles, preempt pulses once, then sel=5 after GAP.
- Coincident rel and timeout on cycle 16 -> exit with preempt=0. Owner drops req[sel] mid-grant -> exit next edge.
- With ARB_LOCK_EN defined: lock=1, req=32'h0000_0002, no rel for 300 cycles -> grant persists, hold_cnt saturates at 255, preempt stays 0.
